decode: RTL and testbench
=========================

# decode

Second pipeline stage of the RV32I core. Accepts `{pc, insn}` pairs from the fetch stage over a valid/ready handshake, splits out the instruction fields, generates the sign-extended immediate, and flags illegal encodings. Results go into a registered output with a one-entry skid buffer, so downstream back-pressure never drops an instruction.

## Interface

**Parameters**
- `AWIDTH`, default 32: PC width.
- `DWIDTH`, default 32: instruction width; only 32 is supported.

**Ports**
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-low (asserted at 0).
- `valid_i`, in, 1: fetch presents a valid instruction.
- `ready_o`, out, 1: decode can accept this cycle.
- `pc_i`, in, AWIDTH: PC of the incoming instruction.
- `insn_i`, in, DWIDTH: incoming instruction word.
- `flush_i`, in, 1: synchronous kill of all held and incoming instructions.
- `valid_o`, out, 1: decoded instruction available.
- `ready_i`, in, 1: downstream accepts this cycle.
- `pc_o`, out, AWIDTH: PC of the decoded instruction.
- `insn_o`, out, DWIDTH: raw instruction word.
- `opcode_o`, out, 7: `insn[6:0]`.
- `rd_o`, out, 5: `insn[11:7]`.
- `funct3_o`, out, 3: `insn[14:12]`.
- `rs1_o`, out, 5: `insn[19:15]`.
- `rs2_o`, out, 5: `insn[24:20]`.
- `funct7_o`, out, 7: `insn[31:25]`.
- `imm_o`, out, 32: sign-extended immediate.
- `illegal_o`, out, 1: unsupported encoding.

## Operation

**Transfers**
- Input transfer: `valid_i & ready_o`.
- Output transfer: `valid_o & ready_i`.

**Decode**
- Fields, immediate and `illegal_o` are computed combinationally from `insn_i`.
- The result is captured into the output register or the skid register, never produced combinationally at the outputs.

**Immediate selection by opcode**
- I-type: 0000011, 0010011, 1100111, 1110011 → `{{20{i[31]}}, i[31:20]}`.
- S-type: 0100011 → `{{20{i[31]}}, i[31:25], i[11:7]}`.
- B-type: 1100011 → `{{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}`.
- U-type: 0110111, 0010111 → `{i[31:12], 12'b0}`.
- J-type: 1101111 → `{{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}`.
- R-type (0110011) and FENCE (0001111) → 0.

**Illegal detection**
- `illegal_o` = 1 when `insn[1:0] != 2'b11`, or when the opcode is not in the list above.
- Illegal instructions still flow through the stage, with `imm_o` = 0.

**State machine** (state register plus `ready_o = (state != SKID)`)
- EMPTY: `valid_i` → load output register → FULL.
- FULL:
  - `valid_i & ready_i` → replace output register, stay FULL.
  - `valid_i & !ready_i` → load skid register → SKID.
  - `!valid_i & ready_i` → EMPTY.
  - Neither → hold.
- SKID:
  - `ready_i` → output register takes the skid contents → FULL.
  - Otherwise hold. No input is accepted.
- `flush_i`: highest priority. Next state is EMPTY, and any input presented that cycle is discarded, even if `ready_o` = 1.
- `valid_o = (state != EMPTY)`.

## Timing

- Latency: one cycle from input transfer to `valid_o`, when the stage was EMPTY or FULL-and-draining.
- Throughput: one instruction per cycle while `ready_i` = 1.
- Outputs are stable while `valid_o & !ready_i` (no change under back-pressure).
- `ready_o` depends only on state; there is no combinational path from `ready_i`.

**Reset (`rst` = 0, asynchronous)**
- State = EMPTY, so `valid_o` = 0 and `ready_o` = 1.
- All data outputs = 0, and the skid register = 0.
- Reset asserted mid-operation discards any held instructions immediately.
- Release of `rst` is synchronized by the top level; the first transfer can occur on the first edge after release.

**Boundary conditions**
- A flush coinciding with an output transfer: the consumer takes the instruction, and the stage still goes EMPTY.
- A held instruction survives an unlimited number of stall cycles.

## Structure

- Shared package `rv32i_pkg`:
  - opcode localparams;
  - `imm_type_e` (I, S, B, U, J, NONE);
  - `decode_state_e` (EMPTY, FULL, SKID);
  - struct `decoded_insn_t` {pc, insn, fields, imm, illegal}, used for both the output and skid registers.
- Sub-module `imm_gen`: combinational, takes `insn` and returns `imm` and `imm_type`.
- Everything else (state machine, registers, field extraction, illegal detection) lives in `decode`.

## Test plan

- Reset: hold `rst` = 0 → `valid_o` = 0, `ready_o` = 1, all outputs 0.
  - Release, send `pc` = 0x01000000, `insn` = 0x00500093 (`addi x1,x0,5`) → next cycle `valid_o` = 1, `rd_o` = 1, `rs1_o` = 0, `imm_o` = 5, `illegal_o` = 0.
- Immediate formats:
  - 0xFE112E23 (`sw x1,-4(x2)`) → `imm_o` = 0xFFFFFFFC.
  - 0xFE000EE3 (`beq` offset -4) → `imm_o` = 0xFFFFFFFC.
  - 0x123452B7 (`lui`) → `imm_o` = 0x12345000.
  - 0xFFDFF06F (`jal` -4) → `imm_o` = 0xFFFFFFFC.
- Back-pressure: stream A, B, C with `ready_i` = 0 from cycle 1.
  - A is held at the outputs, B goes into the skid register, and `ready_o` falls to 0, so C waits.
  - Raise `ready_i` → order A, B, C is observed with no loss or duplication.
- Full throughput: 16 back-to-back instructions with `ready_i` = 1 → 16 outputs on consecutive cycles, PCs incrementing by 4.
- Flush: in SKID, assert `flush_i` together with `valid_i` → next cycle `valid_o` = 0, `ready_o` = 1, and the flushed input never appears.
- Illegal and async reset:
  - `insn` = 0x00000000 → `illegal_o` = 1, `imm_o` = 0.
  - Assert `rst` mid-cycle while in FULL → `valid_o` drops before the next clock edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats, decode stage states and the
// decoded-instruction record held in the output and skid registers.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } decode_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            illegal;
  } decoded_insn_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// returns the sign-extended value; unknown opcodes yield zero and IMM_NONE.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] insn,
  output logic [31:0] imm,
  output imm_type_e   imm_type
);

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    unique case (insn[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        imm_type = IMM_I;
        imm      = {{20{insn[31]}}, insn[31:20]};
      end
      OP_STORE: begin
        imm_type = IMM_S;
        imm      = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        imm      = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_type = IMM_U;
        imm      = {insn[31:12], 12'b0};
      end
      OP_JAL: begin
        imm_type = IMM_J;
        imm      = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      default: begin
        imm_type = IMM_NONE;
        imm      = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: field split, immediate and illegal flag captured into a
// registered output backed by a one-entry skid buffer.
//
// state    | meaning
// ST_EMPTY | nothing held, outputs invalid, input accepted
// ST_FULL  | output register valid, input accepted
// ST_SKID  | output and skid registers both valid, input stalled
module decode
  import rv32i_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);

  decode_state_e r_state;
  decoded_insn_t r_out;
  decoded_insn_t r_skid;

  logic [31:0]   w_insn;
  logic [31:0]   w_imm;
  imm_type_e     w_imm_type;
  logic          w_illegal;
  decoded_insn_t w_dec;

  assign w_insn = 32'(insn_i);

  imm_gen u_imm_gen (
    .insn     (w_insn),
    .imm      (w_imm),
    .imm_type (w_imm_type)
  );

  // R-type and FENCE carry no immediate but are still legal encodings
  assign w_illegal = (w_insn[1:0] != 2'b11) ||
                     ((w_imm_type == IMM_NONE) &&
                      (w_insn[6:0] != OP_OP) && (w_insn[6:0] != OP_FENCE));

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = XLEN'(pc_i);
    w_dec.insn    = w_insn;
    w_dec.opcode  = w_insn[6:0];
    w_dec.rd      = w_insn[11:7];
    w_dec.funct3  = w_insn[14:12];
    w_dec.rs1     = w_insn[19:15];
    w_dec.rs2     = w_insn[24:20];
    w_dec.funct7  = w_insn[31:25];
    w_dec.imm     = w_imm;
    w_dec.illegal = w_illegal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (valid_i) begin
            r_out   <= w_dec;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (valid_i && ready_i) begin
            r_out <= w_dec;
          end else if (valid_i) begin
            r_skid  <= w_dec;
            r_state <= ST_SKID;
          end else if (ready_i) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (ready_i) begin
            r_out   <= r_skid;
            r_state <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign ready_o   = (r_state != ST_SKID);
  assign valid_o   = (r_state != ST_EMPTY);
  assign pc_o      = AWIDTH'(r_out.pc);
  assign insn_o    = DWIDTH'(r_out.insn);
  assign opcode_o  = r_out.opcode;
  assign rd_o      = r_out.rd;
  assign funct3_o  = r_out.funct3;
  assign rs1_o     = r_out.rs1;
  assign rs2_o     = r_out.rs2;
  assign funct7_o  = r_out.funct7;
  assign imm_o     = r_out.imm;
  assign illegal_o = r_out.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: accepted inputs push hand-computed
// expectations, a monitor pops and compares on every output transfer.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] insn_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  decode #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .insn_i(insn_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // output transfer happens at the next rising edge whenever valid_o & ready_i here
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got pc 0x%08h, expected no output", pc_o);
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          chk("pc", pc_o, e.pc);
          chk("insn", insn_o, e.insn);
          chk("fields", {funct7_o, rs2_o, rs1_o, funct3_o, rd_o, opcode_o}, e.insn);
          chk("imm", imm_o, e.imm);
          chk("illegal", {31'b0, illegal_o}, {31'b0, e.ill});
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // caller is aligned just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] pc, input logic [31:0] insn,
                      input logic [31:0] imm, input logic ill);
    bit ok = 0;
    exp_t e;
    valid_i = 1'b1;
    pc_i    = pc;
    insn_i  = insn;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (ready_o && !flush_i) begin
        e.pc = pc; e.insn = insn; e.imm = imm; e.ill = ill;
        sb.push_back(e);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready_o stuck low, expected acceptance of pc 0x%08h", pc);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) sync();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_insn_o", insn_o, 32'd0);
    chk("rst_imm_o", imm_o, 32'd0);
    chk("rst_illegal_o", {31'b0, illegal_o}, 32'd0);
    rst = 1'b1;
    sync();

    // first instruction, one-cycle latency
    ready_i = 1'b1;
    send(32'h0100_0000, 32'h0050_0093, 32'd5, 1'b0);
    @(negedge clk);
    chk("lat_valid_o", {31'b0, valid_o}, 32'd1);
    chk("lat_rd_o", {27'b0, rd_o}, 32'd1);
    chk("lat_rs1_o", {27'b0, rs1_o}, 32'd0);
    chk("lat_imm_o", imm_o, 32'd5);
    sync();

    // immediate formats and illegal encodings
    send(32'h0000_0100, 32'hFE11_2E23, 32'hFFFF_FFFC, 1'b0);
    send(32'h0000_0104, 32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0);
    send(32'h0000_0108, 32'h1234_52B7, 32'h1234_5000, 1'b0);
    send(32'h0000_010C, 32'hFFDF_F06F, 32'hFFFF_FFFC, 1'b0);
    send(32'h0000_0110, 32'h0000_1117, 32'h0000_1000, 1'b0);
    send(32'h0000_0114, 32'hFFF0_0093, 32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0118, 32'h0081_2083, 32'h0000_0008, 1'b0);
    send(32'h0000_011C, 32'h0020_81B3, 32'h0000_0000, 1'b0);
    send(32'h0000_0120, 32'h0000_000F, 32'h0000_0000, 1'b0);
    send(32'h0000_0124, 32'h0000_0000, 32'h0000_0000, 1'b1);
    send(32'h0000_0128, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    drain();

    // back-pressure: A held, B skidded, C stalled, then released in order
    ready_i = 1'b0;
    send(32'h0000_0A00, 32'h0010_0113, 32'd1, 1'b0);
    send(32'h0000_0B00, 32'h0020_0113, 32'd2, 1'b0);
    fork
      send(32'h0000_0C00, 32'h0030_0113, 32'd3, 1'b0);
      begin
        @(negedge clk);
        chk("skid_ready_o", {31'b0, ready_o}, 32'd0);
        for (int k = 0; k < 5; k++) begin
          chk("stall_pc_o", pc_o, 32'h0000_0A00);
          @(negedge clk);
        end
        chk("stall_imm_o", imm_o, 32'd1);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    // full throughput: 16 back-to-back instructions
    base = pop_cyc.size();
    for (int i = 0; i < 16; i++)
      send(32'h0000_2000 + 32'(4 * i), {12'(i + 16), 5'd0, 3'b000, 5'd2, 7'b0010011},
           32'(i + 16), 1'b0);
    drain();
    chk("tput_count", pop_cyc.size() - base, 16);
    if (pop_cyc.size() - base == 16)
      chk("tput_span", pop_cyc[base + 15] - pop_cyc[base], 15);

    // flush while in SKID with a new input presented
    ready_i = 1'b0;
    send(32'h0000_0D00, 32'h0040_0113, 32'd4, 1'b0);
    send(32'h0000_0E00, 32'h0050_0113, 32'd5, 1'b0);
    valid_i = 1'b1;
    pc_i    = 32'h0000_0F00;
    insn_i  = 32'h0060_0113;
    flush_i = 1'b1;
    sync();
    flush_i = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_valid_o", {31'b0, valid_o}, 32'd0);
    chk("flush_ready_o", {31'b0, ready_o}, 32'd1);
    sync();
    ready_i = 1'b1;
    send(32'h0000_1100, 32'h0070_0113, 32'd7, 1'b0);
    drain();

    // flush coinciding with an output transfer
    send(32'h0000_1200, 32'h0080_0113, 32'd8, 1'b0);
    flush_i = 1'b1;
    sync();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_xfer_valid_o", {31'b0, valid_o}, 32'd0);
    chk("flush_xfer_sb", sb.size(), 0);
    sync();

    // asynchronous reset while FULL
    ready_i = 1'b0;
    send(32'h0000_1300, 32'h0090_0113, 32'd9, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid_o", {31'b0, valid_o}, 32'd0);
    chk("arst_ready_o", {31'b0, ready_o}, 32'd1);
    chk("arst_pc_o", pc_o, 32'd0);
    chk("arst_imm_o", imm_o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    sync();
    ready_i = 1'b1;
    send(32'h0000_1400, 32'h00A0_0113, 32'd10, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
